// File: rtl/hazard_detection_unit.sv
// Load-use stall, taken-branch flush and data-memory freeze control for the LEGv8 pipeline.
// Control outputs are Mealy; state, saturating event counters and the wait timeout are registered.
module hazard_detection_unit #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_RegisterRn1,
  input  logic [4:0]       IF_ID_RegisterRm2,
  input  logic             IF_ID_UsesRm,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RegisterRd,
  input  logic             EX_MEM_BranchTaken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             Pipe_Freeze,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] wait_count,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {RUN, BUBBLE, MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT - 1);

  state_t           state, nextState;
  logic             memwait, rdMatch, loaduse;
  logic [CNT_W-1:0] waitRun;

  always_comb begin
    memwait = dmem_req & ~dmem_ready;
    rdMatch = (ID_EX_RegisterRd == IF_ID_RegisterRn1) |
              (IF_ID_UsesRm & (ID_EX_RegisterRd == IF_ID_RegisterRm2));
    // The bubble already sits in ID/EX while in BUBBLE, so the same pair must not stall again.
    loaduse = ID_EX_MemRead & (ID_EX_RegisterRd != 5'd31) & rdMatch & (state != BUBBLE);
  end

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    Pipe_Freeze  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    nextState    = RUN;
    if (memwait) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      Pipe_Freeze = 1'b1;
      nextState   = MEM_WAIT;
    end else if (EX_MEM_BranchTaken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if (loaduse) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      nextState    = BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      stall_count <= '0;
      flush_count <= '0;
      wait_count  <= '0;
      waitRun     <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= nextState;
      if (ID_EX_Bubble && stall_count != '1) stall_count <= stall_count + ONE;
      if (EX_MEM_Flush && flush_count != '1) flush_count <= flush_count + ONE;
      if (Pipe_Freeze && wait_count != '1)   wait_count  <= wait_count + ONE;
      if (!memwait) begin
        waitRun <= '0;
      end else begin
        if (waitRun != '1) waitRun <= waitRun + ONE;
        // Sets at the edge closing the MAX_WAIT-th consecutive wait cycle.
        if (waitRun >= WAIT_LIMIT) mem_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed scoreboard bench for hazard_detection_unit: a wide instance (MAX_WAIT=4)
// and a narrow instance (CNT_W=2, MAX_WAIT=3) share the same stimulus.
module tb_hazard_detection_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rn1, rm2, rd;
  logic       usesRm, memRead, brTaken, req, rdy;

  logic        pcW, ifW, bub, frz, ifF, idF, exF;
  logic [15:0] stallC, flushC, waitC;
  logic        tmo;
  logic        sPcW, sIfW, sBub, sFrz, sIfF, sIdF, sExF;
  logic [1:0]  sStallC, sFlushC, sWaitC;
  logic        sTmo;

  hazard_detection_unit #(.CNT_W(16), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_RegisterRn1(rn1), .IF_ID_RegisterRm2(rm2), .IF_ID_UsesRm(usesRm),
    .ID_EX_MemRead(memRead), .ID_EX_RegisterRd(rd), .EX_MEM_BranchTaken(brTaken),
    .dmem_req(req), .dmem_ready(rdy),
    .PCWrite(pcW), .IF_ID_Write(ifW), .ID_EX_Bubble(bub), .Pipe_Freeze(frz),
    .IF_ID_Flush(ifF), .ID_EX_Flush(idF), .EX_MEM_Flush(exF),
    .stall_count(stallC), .flush_count(flushC), .wait_count(waitC), .mem_timeout(tmo)
  );

  hazard_detection_unit #(.CNT_W(2), .MAX_WAIT(3)) dutSat (
    .clk(clk), .reset(reset),
    .IF_ID_RegisterRn1(rn1), .IF_ID_RegisterRm2(rm2), .IF_ID_UsesRm(usesRm),
    .ID_EX_MemRead(memRead), .ID_EX_RegisterRd(rd), .EX_MEM_BranchTaken(brTaken),
    .dmem_req(req), .dmem_ready(rdy),
    .PCWrite(sPcW), .IF_ID_Write(sIfW), .ID_EX_Bubble(sBub), .Pipe_Freeze(sFrz),
    .IF_ID_Flush(sIfF), .ID_EX_Flush(sIdF), .EX_MEM_Flush(sExF),
    .stall_count(sStallC), .flush_count(sFlushC), .wait_count(sWaitC), .mem_timeout(sTmo)
  );

  always #5 clk = ~clk;

  // Control vector order: {PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush}
  localparam logic [6:0] C_RUN    = 7'b1100000;
  localparam logic [6:0] C_STALL  = 7'b0010000;
  localparam logic [6:0] C_FREEZE = 7'b0001000;
  localparam logic [6:0] C_FLUSH  = 7'b1100111;

  localparam int K_CTL = 0, K_STALL = 1, K_FLUSH = 2, K_WAIT = 3, K_TMO = 4,
                 K_SSTALL = 5, K_SWAIT = 6, K_STMO = 7, K_SCTL = 8;

  typedef struct {
    string       tag;
    int          kind;
    logic [15:0] exp;
  } item_t;

  item_t sb[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic logic [15:0] observe(input int kind);
    case (kind)
      K_CTL:    return {9'b0, pcW, ifW, bub, frz, ifF, idF, exF};
      K_SCTL:   return {9'b0, sPcW, sIfW, sBub, sFrz, sIfF, sIdF, sExF};
      K_STALL:  return stallC;
      K_FLUSH:  return flushC;
      K_WAIT:   return waitC;
      K_TMO:    return {15'b0, tmo};
      K_SSTALL: return {14'b0, sStallC};
      K_SWAIT:  return {14'b0, sWaitC};
      K_STMO:   return {15'b0, sTmo};
      default:  return 16'hxxxx;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int kind, input logic [15:0] exp);
    item_t it;
    it.tag = tag; it.kind = kind; it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic checkAll();
    item_t       it;
    logic [15:0] got;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      got = observe(it.kind);
      vectors++;
      assert (got === it.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, got, it.exp);
      end
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] d, input logic [4:0] n,
                       input logic [4:0] m, input logic u, input logic b,
                       input logic rq, input logic ry);
    memRead = mr; rd = d; rn1 = n; rm2 = m; usesRm = u; brTaken = b; req = rq; rdy = ry;
  endtask

  // Inputs are driven 1 time unit after the rising edge; controls are sampled mid-cycle.
  task automatic cycle(input string tag, input logic [6:0] ctl);
    expect_v(tag, K_CTL, {9'b0, ctl});
    expect_v({tag, "_sat"}, K_SCTL, {9'b0, ctl});
    #3;
    checkAll();
    @(posedge clk);
    #1;
  endtask

  task automatic counts(input string tag, input int st, input int fl, input int wt, input logic to);
    expect_v({tag, "_stall"}, K_STALL, 16'(st));
    expect_v({tag, "_flush"}, K_FLUSH, 16'(fl));
    expect_v({tag, "_wait"},  K_WAIT,  16'(wt));
    expect_v({tag, "_tmo"},   K_TMO,   {15'b0, to});
    checkAll();
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    cycle("reset_ctl", C_RUN);
    counts("reset", 0, 0, 0, 1'b0);
    expect_v("reset_sstall", K_SSTALL, 16'd0);
    checkAll();
    reset = 1'b0;

    // Load-use: LDUR X2 in EX, ADD reading X2 in ID; one bubble only.
    drive(1, 2, 2, 7, 1, 0, 0, 0);
    cycle("lu_stall", C_STALL);
    cycle("lu_bubble", C_RUN);
    counts("lu", 1, 0, 0, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("idle1", C_RUN);

    // XZR destination and an unused Rm never stall; a used Rm does.
    drive(1, 31, 31, 0, 1, 0, 0, 0);
    cycle("xzr", C_RUN);
    drive(1, 5, 1, 5, 0, 0, 0, 0);
    cycle("rm_unused", C_RUN);
    counts("nostall", 1, 0, 0, 1'b0);
    drive(1, 5, 1, 5, 1, 0, 0, 0);
    cycle("rm_used", C_STALL);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("idle2", C_RUN);
    counts("rm", 2, 0, 0, 1'b0);

    // Taken branch overrides load-use; the hazard is seen again once the branch clears.
    drive(1, 3, 3, 0, 0, 1, 0, 0);
    cycle("br_lu", C_FLUSH);
    counts("br", 2, 1, 0, 1'b0);
    drive(1, 3, 3, 0, 0, 0, 0, 0);
    cycle("after_br", C_STALL);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("idle3", C_RUN);
    counts("after_br", 3, 1, 0, 1'b0);

    // Memory wait holds a pending branch; flush lands when ready.
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    cycle("frz1", C_FREEZE);
    cycle("frz2", C_FREEZE);
    cycle("frz3", C_FREEZE);
    counts("frz", 3, 1, 3, 1'b0);
    expect_v("frz_stmo", K_STMO, 16'd1);
    checkAll();
    drive(0, 0, 0, 0, 0, 1, 1, 1);
    cycle("frz_flush", C_FLUSH);
    counts("frz_flush", 3, 2, 3, 1'b0);

    // Leaving MEM_WAIT applies RUN rules, so load-use stalls right away.
    drive(1, 4, 4, 0, 0, 0, 1, 0);
    cycle("lu_frz", C_FREEZE);
    drive(1, 4, 4, 0, 0, 0, 1, 1);
    cycle("lu_exit", C_STALL);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("idle4", C_RUN);
    counts("lu_exit", 4, 2, 4, 1'b0);

    // Timeout at MAX_WAIT=4 consecutive waits, sticky, freeze continues.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 6; i++) begin
      cycle($sformatf("to_frz%0d", i), C_FREEZE);
      expect_v($sformatf("to_tmo%0d", i), K_TMO, {15'b0, (i >= 4)});
      checkAll();
    end
    counts("to", 4, 2, 10, 1'b1);
    expect_v("to_swait_sat", K_SWAIT, 16'd3);
    checkAll();

    // Reset mid-wait: counters, timeout and the consecutive-wait run all clear.
    reset = 1'b1;
    cycle("rst_frz", C_FREEZE);
    counts("rst_wait", 0, 0, 0, 1'b0);
    expect_v("rst_swait", K_SWAIT, 16'd0);
    expect_v("rst_stmo", K_STMO, 16'd0);
    checkAll();
    reset = 1'b0;
    cycle("post_rst1", C_FREEZE);
    cycle("post_rst2", C_FREEZE);
    cycle("post_rst3", C_FREEZE);
    counts("post_rst", 0, 0, 3, 1'b0);

    // Reset mid-bubble returns to RUN, so the held pair stalls again.
    drive(1, 6, 6, 0, 0, 0, 0, 0);
    cycle("rb_stall", C_STALL);
    reset = 1'b1;
    cycle("rb_bubble", C_RUN);
    counts("rb_rst", 0, 0, 0, 1'b0);
    reset = 1'b0;
    cycle("rb_again", C_STALL);
    counts("rb_again", 1, 0, 0, 1'b0);

    // Saturation: nine bubbles, narrow counter stops at 3.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cycle("sat_rst", C_RUN);
    reset = 1'b0;
    expect_v("sat_sstall0", K_SSTALL, 16'd0);
    checkAll();
    drive(1, 9, 9, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++)
      cycle($sformatf("sat%0d", i), (i % 2 == 0) ? C_STALL : C_RUN);
    expect_v("sat_stall_wide", K_STALL, 16'd9);
    expect_v("sat_stall_narrow", K_SSTALL, 16'd3);
    checkAll();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
